clk_step_ctrl: RTL and testbench

- Run/single-step clock-enable controller for the SAP-3 core.
- Sits directly downstream of the clock divider and runs entirely on the divided clock `clk`.
- Produces `cpu_ce`, a one-cycle clock-enable that gates every CPU register update, in one of two modes:
  - free-run mode, at a programmable prescale rate;
  - single-step mode, one pulse per debounced press of an asynchronous step button.
- Stops permanently when the CPU executes HLT.

---
 rtl/clk_ctrl_pkg.sv | 16 +
 rtl/sync_debounce.sv | 69 ++++++
 rtl/clk_step_ctrl.sv | 130 +++++++++++++
 tb/tb_clk_step_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the SAP-3 run/single-step clock-enable controller.
// Holds the controller state encoding and the synchronizer depth.
package clk_ctrl_pkg;

    // Controller states: single-step (reset state), free-run, and the
    // terminal halted state that only reset can leave.
    typedef enum logic [1:0] {
        ST_STEP   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } ctrl_state_t;

    // Depth of every input synchronizer chain in the controller.
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_debounce.sv
// Synchronizer plus debouncer for one asynchronous push-button.
// The raw input passes through a SYNC_STAGES-deep flop chain and is then
// debounced. The debounced level only changes after DEBOUNCE_CYCLES
// consecutive samples that disagree with it.
// Ports:
//   clk   - sampling clock
//   rst_n - asynchronous active-low reset
//   din   - raw asynchronous button input
//   level - debounced button level
//   rise  - one-cycle pulse on a 0->1 change of the debounced level
module sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   prev_q, prev_d;
    logic                   synced;

    // The synchronizer shifts the raw input in at bit 0. The debounce
    // counter runs only while the synced sample disagrees with the current
    // level, and any agreeing sample restarts it. When the counter reaches
    // its last value and the sample still disagrees, the level flips.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        synced  = sync_q[SYNC_STAGES-1];
        level_d = level_q;
        cnt_d   = '0;
        prev_d  = level_q;
        if (synced != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = synced;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Register stage for the synchronizer, counter, and debounced history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= prev_d;
        end
    end

    assign level = level_q;
    assign rise  = level_q & ~prev_q;

endmodule

// File: rtl/clk_step_ctrl.sv
// Run/single-step clock-enable controller for the SAP-3 core.
// The controller generates cpu_ce, a one-cycle enable for every CPU register
// update. In free-run mode cpu_ce pulses once every prescale+1 cycles. In
// single-step mode cpu_ce pulses once per debounced step-button press. An
// accepted halt stops cpu_ce until reset.
// Ports:
//   clk      - divided system clock
//   rst_n    - asynchronous active-low reset
//   run_mode - async switch, 1 = free-run, 0 = single-step
//   step_btn - async step push-button, active-high
//   prescale - free-run period minus one, quasi-static
//   hlt      - CPU halt request, synchronous to clk
//   cpu_ce   - registered clock-enable to the CPU
//   halted   - registered, high once a halt has been accepted
//   stepping - registered, high while in single-step mode
module clk_step_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int PRESCALE_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run_mode,
    input  logic                  step_btn,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  hlt,
    output logic                  cpu_ce,
    output logic                  halted,
    output logic                  stepping
);

    ctrl_state_t           state_q, state_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic                  cpu_ce_q, cpu_ce_d;
    logic                  halted_q, halted_d;
    logic                  stepping_q, stepping_d;
    logic [1:0]            run_sync_q, run_sync_d;
    logic                  run_synced;
    logic                  step_level;
    logic                  step_rise;
    logic                  step_req;

    sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_step_db (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (step_btn),
        .level(step_level),
        .rise (step_rise)
    );

    // A request needs a fresh rising edge with the debounced level still high.
    assign step_req   = step_rise & step_level;
    assign run_synced = run_sync_q[1];

    // Next-state logic. hlt is checked before every other condition so that
    // it wins over a terminal count, a step request, or a mode change in the
    // same cycle. The free-run compare uses >= so that lowering prescale
    // below the current count ends the period at once and does not wrap.
    always_comb begin
        run_sync_d = {run_sync_q[0], run_mode};
        state_d    = state_q;
        cnt_d      = cnt_q;
        cpu_ce_d   = 1'b0;
        halted_d   = halted_q;
        case (state_q)
            ST_RUN: begin
                if (hlt) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end else if (!run_synced) begin
                    state_d = ST_STEP;
                    cnt_d   = '0;
                end else if (cnt_q >= prescale) begin
                    cpu_ce_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STEP: begin
                if (hlt) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end else if (run_synced) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cpu_ce_d = step_req;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_STEP;
                cnt_d   = '0;
            end
        endcase
        stepping_d = (state_d == ST_STEP);
    end

    // State registers. Reset lands in single-step mode with every counter
    // and synchronizer cleared, and drops cpu_ce without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_STEP;
            cnt_q      <= '0;
            cpu_ce_q   <= 1'b0;
            halted_q   <= 1'b0;
            stepping_q <= 1'b1;
            run_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cpu_ce_q   <= cpu_ce_d;
            halted_q   <= halted_d;
            stepping_q <= stepping_d;
            run_sync_q <= run_sync_d;
        end
    end

    assign cpu_ce   = cpu_ce_q;
    assign halted   = halted_q;
    assign stepping = stepping_q;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed testbench for clk_step_ctrl with DEBOUNCE_CYCLES = 4.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected values are derived by hand from the controller timing.
module tb_clk_step_ctrl;

    localparam int DEBOUNCE_CYCLES = 4;
    localparam int PRESCALE_W      = 8;
    localparam int STEP_EDGE       = DEBOUNCE_CYCLES + 3;

    logic                  clk;
    logic                  rst_n;
    logic                  run_mode;
    logic                  step_btn;
    logic [PRESCALE_W-1:0] prescale;
    logic                  hlt;
    logic                  cpu_ce;
    logic                  halted;
    logic                  stepping;

    int vectorCount = 0;
    int missCount   = 0;

    clk_step_ctrl #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .PRESCALE_W     (PRESCALE_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run_mode(run_mode),
        .step_btn(step_btn),
        .prescale(prescale),
        .hlt     (hlt),
        .cpu_ce  (cpu_ce),
        .halted  (halted),
        .stepping(stepping)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive every synchronous and asynchronous input at once.
    task automatic applyStimulus(input logic run, input logic btn,
                                 input logic [PRESCALE_W-1:0] pre, input logic h);
        run_mode = run;
        step_btn = btn;
        prescale = pre;
        hlt      = h;
    endtask

    // Compare one observed output bit against its expected value.
    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        vectorCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, obs, exp);
        end
    endtask

    // Advance from one falling edge to the next, passing one rising edge.
    task automatic nextCycle();
        @(negedge clk);
    endtask

    // Press the button in step mode and hold it. Exactly one pulse appears
    // after edge STEP_EDGE. The button is then released and the bench waits
    // for the debounced level to settle.
    task automatic pressAndCheck(input string name);
        applyStimulus(1'b0, 1'b1, prescale, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            nextCycle();
            checkOutput($sformatf("%s ce edge%0d", name, k), cpu_ce, (k == STEP_EDGE));
            checkOutput($sformatf("%s stepping edge%0d", name, k), stepping, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, prescale, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            nextCycle();
            checkOutput($sformatf("%s release ce%0d", name, k), cpu_ce, 1'b0);
        end
    endtask

    // Switch to free-run mode. The mode change is visible three edges later.
    task automatic enterRun(input string name, input logic [PRESCALE_W-1:0] pre);
        applyStimulus(1'b1, 1'b0, pre, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            nextCycle();
            checkOutput($sformatf("%s stepping%0d", name, k), stepping, (k < 3));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        nextCycle();
        nextCycle();
        checkOutput("reset ce", cpu_ce, 1'b0);
        checkOutput("reset halted", halted, 1'b0);
        checkOutput("reset stepping", stepping, 1'b1);
        rst_n = 1'b1;

        // Single press in step mode.
        $display("[TB] single step press");
        pressAndCheck("press1");

        // Bounce shorter than the debounce window.
        $display("[TB] bounce rejection");
        for (int k = 0; k < 30; k++) begin
            applyStimulus(1'b0, ((k / 2) % 2) == 0, 8'd0, 1'b0);
            nextCycle();
            checkOutput($sformatf("bounce ce%0d", k), cpu_ce, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            nextCycle();
            checkOutput($sformatf("bounce idle ce%0d", k), cpu_ce, 1'b0);
        end

        // Free-run timing, prescale 0, and prescale changes mid-count.
        $display("[TB] free run");
        enterRun("run3", 8'd3);
        for (int k = 1; k <= 12; k++) begin
            nextCycle();
            checkOutput($sformatf("pre3 ce%0d", k), cpu_ce, (k % 4) == 0);
        end
        applyStimulus(1'b1, 1'b0, 8'd0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            nextCycle();
            checkOutput($sformatf("pre0 ce%0d", k), cpu_ce, 1'b1);
        end
        applyStimulus(1'b1, 1'b0, 8'd7, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            nextCycle();
            checkOutput($sformatf("pre7 ce%0d", k), cpu_ce, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 8'd5, 1'b0);
        nextCycle();
        checkOutput("pre5 cnt4 ce", cpu_ce, 1'b0);
        nextCycle();
        checkOutput("pre5 cnt5 ce", cpu_ce, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            nextCycle();
            checkOutput($sformatf("pre5 ce%0d", k), cpu_ce, (k == 6));
        end
        applyStimulus(1'b1, 1'b0, 8'd7, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            nextCycle();
            checkOutput($sformatf("lower pre7 ce%0d", k), cpu_ce, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 8'd3, 1'b0);
        nextCycle();
        checkOutput("lower to 3 ce", cpu_ce, 1'b1);

        // Halt at the terminal count, then everything is ignored until reset.
        $display("[TB] halt");
        applyStimulus(1'b1, 1'b0, 8'd2, 1'b0);
        for (int k = 1; k <= 2; k++) begin
            nextCycle();
            checkOutput($sformatf("pre2 ce%0d", k), cpu_ce, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 8'd2, 1'b1);
        nextCycle();
        checkOutput("hlt ce", cpu_ce, 1'b0);
        checkOutput("hlt halted", halted, 1'b1);
        checkOutput("hlt stepping", stepping, 1'b0);
        for (int k = 0; k < 36; k++) begin
            applyStimulus((k >= 12 && k < 24) ? 1'b0 : 1'b1, (k < 12), 8'd2, 1'b0);
            nextCycle();
            checkOutput($sformatf("halted ce%0d", k), cpu_ce, 1'b0);
            checkOutput($sformatf("halted flag%0d", k), halted, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 8'd2, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("halt reset halted", halted, 1'b0);
        checkOutput("halt reset stepping", stepping, 1'b1);
        nextCycle();
        rst_n = 1'b1;

        // Leave free-run and take a single step.
        $display("[TB] run to step");
        enterRun("run1", 8'd1);
        for (int k = 1; k <= 6; k++) begin
            nextCycle();
            checkOutput($sformatf("pre1 ce%0d", k), cpu_ce, (k % 2) == 0);
        end
        applyStimulus(1'b0, 1'b0, 8'd1, 1'b0);
        for (int k = 1; k <= 3; k++) nextCycle();
        checkOutput("to step stepping", stepping, 1'b1);
        checkOutput("to step ce", cpu_ce, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            nextCycle();
            checkOutput($sformatf("step idle ce%0d", k), cpu_ce, 1'b0);
        end
        pressAndCheck("press2");

        // Asynchronous reset while cpu_ce is high.
        $display("[TB] async reset");
        enterRun("run0", 8'd0);
        nextCycle();
        nextCycle();
        checkOutput("pre reset ce", cpu_ce, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset ce", cpu_ce, 1'b0);
        checkOutput("async reset halted", halted, 1'b0);
        checkOutput("async reset stepping", stepping, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 8'd0, 1'b0);
        rst_n = 1'b1;
        nextCycle();
        checkOutput("after reset ce", cpu_ce, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
